// File: rtl/rr_arb_pkg.sv
// Shared constants and helpers for the round-robin one-hot arbiter.
package rr_arb_pkg;

  localparam int N_DEF = 8;

  // Pointer width for n sources; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Advance the round-robin pointer, wrapping n-1 -> 0.
  function automatic int unsigned wrap_inc(input int unsigned p, input int unsigned n);
    return (p >= n - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/rr_onehot_arbiter_if.sv
// Request/grant bundle between sources, the arbiter and the encoder stage.
interface rr_onehot_arbiter_if
  import rr_arb_pkg::*;
#(
  parameter int N = N_DEF
);

  logic [N-1:0] req;
  logic         gnt_ready;
  logic         gnt_valid;
  logic [N-1:0] gnt_onehot;
  logic [N-1:0] pend;

  // Requesting/consuming side.
  modport master (
    output req, gnt_ready,
    input  gnt_valid, gnt_onehot, pend
  );

  // Arbiter side.
  modport slave (
    input  req, gnt_ready,
    output gnt_valid, gnt_onehot, pend
  );

endinterface

// File: rtl/rr_onehot_arbiter_pick.sv
// Combinational first-set picker: one-hot of the first set bit of i_vec at or
// after i_start, wrapping N-1 -> 0. All-zero when i_vec is empty.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     i_vec,
  input  logic [IDX_W-1:0] i_start,
  output logic [N-1:0]     o_onehot
);

  logic w_found;

  // Upper segment [start, N-1] first, then the wrapped segment [0, N-1].
  always_comb begin
    o_onehot = '0;
    w_found  = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!w_found && i_vec[i] && (i >= 32'(i_start))) begin
        o_onehot[i] = 1'b1;
        w_found     = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!w_found && i_vec[i]) begin
        o_onehot[i] = 1'b1;
        w_found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter: sticky pending bits from request pulses, one registered
// one-hot grant at a time over a valid/ready handshake.
module rr_onehot_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int IDX_W = idx_w(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rr_onehot_arbiter_if.slave    bus
);

  logic [N-1:0]     r_pend;
  logic [N-1:0]     r_gnt;
  logic             r_valid;
  logic [IDX_W-1:0] r_ptr;

  logic             w_acc;
  logic [N-1:0]     w_acc_mask;
  logic [N-1:0]     w_pend_nxt;
  logic             w_slot_free;
  logic [IDX_W-1:0] w_gnt_idx;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic [N-1:0]     w_pick;

  // Handshake, pending update and pointer advance past the accepted source.
  always_comb begin
    w_gnt_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (r_gnt[i]) w_gnt_idx = w_gnt_idx | IDX_W'(i);
    end
    w_acc       = r_valid & bus.gnt_ready;
    w_acc_mask  = w_acc ? r_gnt : '0;
    w_pend_nxt  = (r_pend & ~w_acc_mask) | bus.req;
    w_slot_free = ~r_valid | w_acc;
    w_ptr_nxt   = w_acc ? IDX_W'(wrap_inc(32'(w_gnt_idx), N)) : r_ptr;
  end

  rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_vec    (w_pend_nxt),
    .i_start  (w_ptr_nxt),
    .o_onehot (w_pick)
  );

  // State registers; grant only reloads when the slot is free, so it holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend  <= '0;
      r_gnt   <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      r_ptr  <= w_ptr_nxt;
      if (w_slot_free) begin
        r_valid <= |w_pend_nxt;
        r_gnt   <= w_pick;
      end
    end
  end

  assign bus.gnt_valid  = r_valid;
  assign bus.gnt_onehot = r_gnt;
  assign bus.pend       = r_pend;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed bench for rr_onehot_arbiter: N=8 instance plus an N=5 instance.
module tb_rr_onehot_arbiter;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  rr_onehot_arbiter_if #(.N(8)) bus8 ();
  rr_onehot_arbiter_if #(.N(5)) bus5 ();

  rr_onehot_arbiter #(.N(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  rr_onehot_arbiter #(.N(5)) dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Grant bus must be one-hot or zero, and zero whenever not valid.
  always @(negedge clk) begin
    n_cmp = n_cmp + 2;
    if (!$onehot0(bus8.gnt_onehot) || (!bus8.gnt_valid && bus8.gnt_onehot !== 8'h00)) begin
      n_bad = n_bad + 1;
      $display("FAIL onehot0_n8 got=%h valid=%b", bus8.gnt_onehot, bus8.gnt_valid);
    end
    if (!$onehot0(bus5.gnt_onehot) || (!bus5.gnt_valid && bus5.gnt_onehot !== 5'h00)) begin
      n_bad = n_bad + 1;
      $display("FAIL onehot0_n5 got=%h valid=%b", bus5.gnt_onehot, bus5.gnt_valid);
    end
  end

  task automatic do_reset(input logic [7:0] req8, input logic rdy8);
    @(negedge clk);
    rst_n = 1'b0;
    bus8.req = req8;
    bus8.gnt_ready = rdy8;
    bus5.req = 5'h00;
    bus5.gnt_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    bus8.req = 8'hFF;
    bus8.gnt_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp = n_cmp + 1;
    if ({bus8.gnt_valid, bus8.gnt_onehot, bus8.pend} !== 17'h0) begin
      n_bad = n_bad + 1;
      $display("FAIL reset_state got v=%b g=%h p=%h want 0/00/00", bus8.gnt_valid, bus8.gnt_onehot, bus8.pend);
    end
    @(negedge clk);
    n_cmp = n_cmp + 1;
    if ({bus8.gnt_valid, bus8.gnt_onehot, bus8.pend} !== 17'h0) begin
      n_bad = n_bad + 1;
      $display("FAIL reset_hold got v=%b g=%h p=%h want 0/00/00", bus8.gnt_valid, bus8.gnt_onehot, bus8.pend);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp = n_cmp + 1;
    if (bus8.gnt_valid !== 1'b1 || bus8.gnt_onehot !== 8'h01) begin
      n_bad = n_bad + 1;
      $display("FAIL reset_first_grant got v=%b g=%h want 1/01", bus8.gnt_valid, bus8.gnt_onehot);
    end
  endtask

  task automatic test_rotation;
    logic [7:0] exp [9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    do_reset(8'hFF, 1'b1);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      n_cmp = n_cmp + 1;
      if (bus8.gnt_valid !== 1'b1 || bus8.gnt_onehot !== exp[k]) begin
        n_bad = n_bad + 1;
        $display("FAIL rotation[%0d] got v=%b g=%h want 1/%h", k, bus8.gnt_valid, bus8.gnt_onehot, exp[k]);
      end
    end
  endtask

  task automatic test_backpressure;
    do_reset(8'h00, 1'b0);
    bus8.req = 8'h24;
    @(negedge clk);
    bus8.req = 8'h00;
    for (int k = 0; k < 5; k++) begin
      n_cmp = n_cmp + 1;
      if (bus8.gnt_valid !== 1'b1 || bus8.gnt_onehot !== 8'h04 || bus8.pend !== 8'h24) begin
        n_bad = n_bad + 1;
        $display("FAIL bp_hold[%0d] got v=%b g=%h p=%h want 1/04/24", k, bus8.gnt_valid, bus8.gnt_onehot, bus8.pend);
      end
      @(negedge clk);
    end
    bus8.gnt_ready = 1'b1;
    @(negedge clk);
    n_cmp = n_cmp + 1;
    if (bus8.gnt_valid !== 1'b1 || bus8.gnt_onehot !== 8'h20 || bus8.pend !== 8'h20) begin
      n_bad = n_bad + 1;
      $display("FAIL bp_second got v=%b g=%h p=%h want 1/20/20", bus8.gnt_valid, bus8.gnt_onehot, bus8.pend);
    end
    @(negedge clk);
    n_cmp = n_cmp + 1;
    if (bus8.gnt_valid !== 1'b0 || bus8.gnt_onehot !== 8'h00 || bus8.pend !== 8'h00) begin
      n_bad = n_bad + 1;
      $display("FAIL bp_drain got v=%b g=%h p=%h want 0/00/00", bus8.gnt_valid, bus8.gnt_onehot, bus8.pend);
    end
  endtask

  task automatic test_rerequest;
    logic [7:0] exp_g [4] = '{8'h02, 8'h04, 8'h01, 8'h00};
    logic [7:0] exp_p [4] = '{8'h07, 8'h05, 8'h01, 8'h00};
    do_reset(8'h00, 1'b0);
    bus8.req = 8'h07;
    @(negedge clk);
    n_cmp = n_cmp + 1;
    if (bus8.gnt_onehot !== 8'h01 || bus8.pend !== 8'h07) begin
      n_bad = n_bad + 1;
      $display("FAIL rereq_first got g=%h p=%h want 01/07", bus8.gnt_onehot, bus8.pend);
    end
    bus8.req = 8'h01;
    bus8.gnt_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus8.req = 8'h00;
      n_cmp = n_cmp + 1;
      if (bus8.gnt_onehot !== exp_g[k] || bus8.pend !== exp_p[k] || bus8.gnt_valid !== (exp_g[k] != 8'h00)) begin
        n_bad = n_bad + 1;
        $display("FAIL rereq[%0d] got v=%b g=%h p=%h want g=%h p=%h", k, bus8.gnt_valid, bus8.gnt_onehot, bus8.pend, exp_g[k], exp_p[k]);
      end
    end
  endtask

  task automatic test_async_reset;
    do_reset(8'h00, 1'b0);
    bus8.req = 8'h10;
    @(negedge clk);
    bus8.req = 8'h00;
    n_cmp = n_cmp + 1;
    if (bus8.gnt_valid !== 1'b1 || bus8.gnt_onehot !== 8'h10 || bus8.pend !== 8'h10) begin
      n_bad = n_bad + 1;
      $display("FAIL async_pre got v=%b g=%h p=%h want 1/10/10", bus8.gnt_valid, bus8.gnt_onehot, bus8.pend);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp = n_cmp + 1;
    if ({bus8.gnt_valid, bus8.gnt_onehot, bus8.pend} !== 17'h0) begin
      n_bad = n_bad + 1;
      $display("FAIL async_drop got v=%b g=%h p=%h want 0/00/00", bus8.gnt_valid, bus8.gnt_onehot, bus8.pend);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_n5_wrap;
    logic [4:0] exp [3] = '{5'h01, 5'h10, 5'h01};
    do_reset(8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    bus5.req = 5'h11;
    bus5.gnt_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp = n_cmp + 1;
      if (bus5.gnt_valid !== 1'b1 || bus5.gnt_onehot !== exp[k] || bus5.pend !== 5'h11) begin
        n_bad = n_bad + 1;
        $display("FAIL n5_wrap[%0d] got v=%b g=%h p=%h want 1/%h/11", k, bus5.gnt_valid, bus5.gnt_onehot, bus5.pend, exp[k]);
      end
    end
    bus5.req = 5'h00;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus8.req = 8'h00;
    bus8.gnt_ready = 1'b0;
    bus5.req = 5'h00;
    bus5.gnt_ready = 1'b0;
    test_reset();
    test_rotation();
    test_backpressure();
    test_rerequest();
    test_async_reset();
    test_n5_wrap();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

endmodule
